ex_muldiv: RTL and testbench

Multiply/divide unit in the EX stage, fed directly by the ID/EX pipeline register. It takes forwarded operands and an MD opcode from the ID/EX outputs. It runs multi-cycle signed and unsigned multiply and divide into the architectural HI/LO registers, and serves mfhi/mflo reads. It also produces the ID-stage stall request, so MD instructions cannot overtake an in-flight operation.

---
 rtl/md_pkg.sv | 21 ++
 rtl/ex_muldiv.sv | 132 +++++++++++++
 tb/tb_ex_muldiv.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit and the ID decoder.
package md_pkg;

    // MD opcode carried through ID/EX; MD_NONE marks any non-MD (or flushed) slot.
    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_e;

    // Default busy periods.
    localparam int unsigned MD_MULT_CYCLES = 5;
    localparam int unsigned MD_DIV_CYCLES  = 10;

endpackage

// File: rtl/ex_muldiv.sv
// Multi-cycle multiply/divide unit with architectural HI/LO and ID stall request.
module ex_muldiv
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  mdOpE,
    input  logic [31:0] AE,
    input  logic [31:0] BE,
    input  logic        mdInstrD,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDOutE,
    output logic        mdStall
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

    logic          busy_q, busy_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   phi_q, phi_d;
    logic [31:0]   plo_q, plo_d;
    logic          dz_q, dz_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;

    logic          is_mul, is_div, start;
    logic [63:0]   result;

    // Operation decode and 64-bit result of the op presented in EX.
    always_comb begin
        logic signed [63:0] a64;
        logic signed [63:0] b64;
        logic signed [31:0] sdivisor;
        logic        [31:0] udivisor;
        logic signed [31:0] squot;
        logic signed [31:0] srem;

        is_mul   = (mdOpE == MD_MULT) || (mdOpE == MD_MULTU);
        is_div   = (mdOpE == MD_DIV)  || (mdOpE == MD_DIVU);
        start    = (is_mul || is_div) && !busy_q;

        a64      = {{32{AE[31]}}, AE};
        b64      = {{32{BE[31]}}, BE};
        sdivisor = (BE == '0) ? 32'sd1 : $signed(BE);
        udivisor = (BE == '0) ? 32'd1  : BE;
        squot    = $signed(AE) / sdivisor;
        srem     = $signed(AE) % sdivisor;
        // The most-negative / -1 case overflows the quotient; pin it to the wrapped value.
        if (AE == 32'h8000_0000 && BE == '1) begin
            squot = $signed(32'h8000_0000);
            srem  = '0;
        end

        result = '0;
        case (mdOpE)
            MD_MULT:  result = $signed(a64) * $signed(b64);
            MD_MULTU: result = $unsigned({32'd0, AE}) * $unsigned({32'd0, BE});
            MD_DIV:   result = {srem, squot};
            MD_DIVU:  result = {$unsigned(AE) % udivisor, $unsigned(AE) / udivisor};
            default:  result = '0;
        endcase
    end

    // Next-state logic: start, count down, commit, and mthi/mtlo writes.
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        phi_d  = phi_q;
        plo_d  = plo_q;
        dz_d   = dz_q;
        hi_d   = hi_q;
        lo_d   = lo_q;

        if (busy_q) begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                if (!dz_q) begin
                    hi_d = phi_q;
                    lo_d = plo_q;
                end
            end
        end else if (start) begin
            busy_d = 1'b1;
            cnt_d  = is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            phi_d  = result[63:32];
            plo_d  = result[31:0];
            dz_d   = is_div && (BE == '0);
        end else if (mdOpE == MD_MTHI) begin
            hi_d = AE;
        end else if (mdOpE == MD_MTLO) begin
            lo_d = AE;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            phi_q  <= '0;
            plo_q  <= '0;
            dz_q   <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            phi_q  <= phi_d;
            plo_q  <= plo_d;
            dz_q   <= dz_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

    // Outputs: architectural registers, mf read mux and ID stall.
    always_comb begin
        busy    = busy_q;
        HI      = hi_q;
        LO      = lo_q;
        MDOutE  = (mdOpE == MD_MFHI) ? hi_q : (mdOpE == MD_MFLO) ? lo_q : '0;
        mdStall = (busy_q || start) && mdInstrD;
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv with a behavioural arithmetic model.
module tb_ex_muldiv;
    import md_pkg::*;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  mdOpE;
    logic [31:0] AE, BE;
    logic        mdInstrD;
    logic        busy, mdStall;
    logic [31:0] HI, LO, MDOutE;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_hi, m_lo;

    ex_muldiv #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .mdOpE(mdOpE), .AE(AE), .BE(BE),
        .mdInstrD(mdInstrD), .busy(busy), .HI(HI), .LO(LO),
        .MDOutE(MDOutE), .mdStall(mdStall)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Architectural effect of an op on HI/LO, from plain integer arithmetic.
    function automatic void model_apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      p, q, r;
        logic [63:0] u;
        case (op)
            MD_MULT: begin
                p = longint'($signed(a)) * longint'($signed(b));
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            MD_MULTU: begin
                u = {32'd0, a} * {32'd0, b};
                m_hi = u[63:32]; m_lo = u[31:0];
            end
            MD_DIV: if (b != 0) begin
                q = longint'($signed(a)) / longint'($signed(b));
                r = longint'($signed(a)) % longint'($signed(b));
                m_lo = q[31:0]; m_hi = r[31:0];
            end
            MD_DIVU: if (b != 0) begin
                m_lo = a / b; m_hi = a % b;
            end
            MD_MTHI: m_hi = a;
            MD_MTLO: m_lo = a;
            default: ;
        endcase
    endfunction

    function automatic int unsigned op_cycles(input logic [3:0] op);
        if (op == MD_MULT || op == MD_MULTU) return MC;
        if (op == MD_DIV || op == MD_DIVU) return DC;
        return 0;
    endfunction

    // Issue one op from idle, check the busy window and the committed HI/LO.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned n;
        n = op_cycles(op);
        mdOpE = op; AE = a; BE = b;
        tick();
        mdOpE = MD_NONE; AE = $urandom; BE = $urandom;
        for (int unsigned i = 0; i < n; i++) begin
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_window op=%0d cyc=%0d busy=%b want 1", op, i + 1, busy);
            end
            checks++;
            if (HI !== m_hi || LO !== m_lo) begin
                errors++;
                $display("FAIL hilo_hidden op=%0d cyc=%0d HI=%h LO=%h want %h %h", op, i + 1, HI, LO, m_hi, m_lo);
            end
            tick();
        end
        model_apply(op, a, b);
        checks++;
        if (busy !== 1'b0 || HI !== m_hi || LO !== m_lo) begin
            errors++;
            $display("FAIL result op=%0d a=%h b=%h busy=%b HI=%h LO=%h want busy=0 HI=%h LO=%h",
                     op, a, b, busy, HI, LO, m_hi, m_lo);
        end
        mdOpE = MD_MFHI; #1;
        checks++;
        if (MDOutE !== m_hi) begin
            errors++;
            $display("FAIL mfhi MDOutE=%h want %h", MDOutE, m_hi);
        end
        mdOpE = MD_MFLO; #1;
        checks++;
        if (MDOutE !== m_lo) begin
            errors++;
            $display("FAIL mflo MDOutE=%h want %h", MDOutE, m_lo);
        end
        mdOpE = MD_NONE;
    endtask

    task automatic test_reset();
        reset = 1'b1; mdOpE = MD_NONE; AE = '0; BE = '0; mdInstrD = 1'b0;
        tick(); tick();
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        #1;
        checks++;
        if (busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0 || MDOutE !== 32'h0 || mdStall !== 1'b0) begin
            errors++;
            $display("FAIL reset_state busy=%b HI=%h LO=%h MDOutE=%h mdStall=%b want all 0",
                     busy, HI, LO, MDOutE, mdStall);
        end
    endtask

    task automatic test_directed();
        run_op(MD_MULT, 32'hFFFF_FFFF, 32'd2);
        checks++;
        if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL mult_const HI=%h LO=%h want ffffffff fffffffe", HI, LO);
        end
        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
        checks++;
        if (HI !== 32'h0000_0001 || LO !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL multu_const HI=%h LO=%h want 00000001 fffffffe", HI, LO);
        end
        run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        checks++;
        if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD) begin
            errors++;
            $display("FAIL div_const HI=%h LO=%h want ffffffff fffffffd", HI, LO);
        end
        run_op(MD_DIVU, 32'd7, 32'd2);
        checks++;
        if (HI !== 32'd1 || LO !== 32'd3) begin
            errors++;
            $display("FAIL divu_const HI=%h LO=%h want 1 3", HI, LO);
        end
    endtask

    task automatic test_div_corner();
        run_op(MD_MTHI, 32'h1234, 32'd0);
        run_op(MD_MTLO, 32'h5678, 32'd0);
        run_op(MD_DIV, 32'd99, 32'd0);
        checks++;
        if (HI !== 32'h1234 || LO !== 32'h5678) begin
            errors++;
            $display("FAIL div_by_zero HI=%h LO=%h want 00001234 00005678", HI, LO);
        end
        run_op(MD_DIVU, 32'd5, 32'd0);
        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        checks++;
        if (HI !== 32'h0 || LO !== 32'h8000_0000) begin
            errors++;
            $display("FAIL div_overflow HI=%h LO=%h want 00000000 80000000", HI, LO);
        end
    endtask

    task automatic test_stall();
        logic [31:0] a, b;
        a = $urandom; b = $urandom;
        mdInstrD = 1'b1;
        mdOpE = MD_NONE; #1;
        checks++;
        if (mdStall !== 1'b0) begin
            errors++;
            $display("FAIL stall_idle mdStall=%b want 0", mdStall);
        end
        mdOpE = MD_MULT; AE = a; BE = b; #1;
        checks++;
        if (mdStall !== 1'b1) begin
            errors++;
            $display("FAIL stall_start mdStall=%b want 1", mdStall);
        end
        tick();
        for (int unsigned i = 0; i < MC; i++) begin
            mdOpE = (i == 1) ? MD_MULT : (i == 2) ? MD_MTHI : MD_NONE;
            AE = $urandom; BE = $urandom; #1;
            checks++;
            if (mdStall !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL stall_busy cyc=%0d mdStall=%b busy=%b want 1 1", i + 1, mdStall, busy);
            end
            tick();
        end
        model_apply(MD_MULT, a, b);
        mdOpE = MD_MFHI; #1;
        checks++;
        if (busy !== 1'b0 || mdStall !== 1'b0 || MDOutE !== m_hi) begin
            errors++;
            $display("FAIL mfhi_at_fall busy=%b mdStall=%b MDOutE=%h want 0 0 %h", busy, mdStall, MDOutE, m_hi);
        end
        checks++;
        if (LO !== m_lo) begin
            errors++;
            $display("FAIL ignored_op LO=%h want %h", LO, m_lo);
        end
        mdInstrD = 1'b0; mdOpE = MD_NONE;
        tick();
    endtask

    task automatic test_reset_mid();
        run_op(MD_MTHI, 32'hDEAD_BEEF, 32'd0);
        run_op(MD_MTLO, 32'hCAFE_F00D, 32'd0);
        mdOpE = MD_DIV; AE = 32'd1000; BE = 32'd7;
        tick();
        mdOpE = MD_NONE;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        checks++;
        if (busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin
            errors++;
            $display("FAIL reset_abort busy=%b HI=%h LO=%h want 0 0 0", busy, HI, LO);
        end
        for (int unsigned i = 0; i < DC + 2; i++) tick();
        checks++;
        if (busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin
            errors++;
            $display("FAIL reset_no_late_write busy=%b HI=%h LO=%h want 0 0 0", busy, HI, LO);
        end
        // Reset wins over a simultaneous start.
        mdOpE = MD_MULT; AE = 32'd3; BE = 32'd3; reset = 1'b1;
        tick();
        reset = 1'b0; mdOpE = MD_NONE;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_vs_start busy=%b want 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a2, b2;
        a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
        mdOpE = MD_MULT; AE = a1; BE = b1;
        tick();
        mdOpE = MD_NONE;
        for (int unsigned i = 0; i < MC; i++) tick();
        model_apply(MD_MULT, a1, b1);
        checks++;
        if (busy !== 1'b0 || HI !== m_hi || LO !== m_lo) begin
            errors++;
            $display("FAIL b2b_first busy=%b HI=%h LO=%h want 0 %h %h", busy, HI, LO, m_hi, m_lo);
        end
        mdOpE = MD_MULTU; AE = a2; BE = b2;
        tick();
        mdOpE = MD_NONE;
        for (int unsigned i = 0; i < MC; i++) begin
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL b2b_window cyc=%0d busy=%b want 1", i + 1, busy);
            end
            tick();
        end
        model_apply(MD_MULTU, a2, b2);
        checks++;
        if (busy !== 1'b0 || HI !== m_hi || LO !== m_lo) begin
            errors++;
            $display("FAIL b2b_second busy=%b HI=%h LO=%h want 0 %h %h", busy, HI, LO, m_hi, m_lo);
        end
    endtask

    task automatic test_random();
        logic [3:0]  ops [6];
        logic [31:0] a, b;
        ops = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO};
        for (int unsigned k = 0; k < 30; k++) begin
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 9) == 0) b = $urandom_range(1, 9);
            run_op(ops[$urandom_range(0, 5)], a, b);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_corner();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
